// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states, word-select polarity
// and default synchronizer depth (also used by the I2S transmitter).
package i2s_pkg;

    localparam int SYNC_N_DEF = 2;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// I2S receive bus: serial pins in, parallel stereo frame out.
// master = pin driver / frame consumer, slave = the receiver.
interface i2s_rx_if #(
    parameter int DATA_W = 16
);
    logic              bclk;
    logic              ws;
    logic              sd;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              frame_valid;
    logic              err;

    modport master (
        output bclk, ws, sd,
        input  left_data, right_data, frame_valid, err
    );

    modport slave (
        input  bclk, ws, sd,
        output left_data, right_data, frame_valid, err
    );
endinterface

// File: rtl/i2s_sync.sv
// SYNC_N-stage synchronizer for bclk/ws/sd plus bclk rising-edge detect.
// Ports: clk, rst_n (sync, active-low), bclk/ws/sd in; bclk_rise, ws_s, sd_s out.
module i2s_sync #(
    parameter int SYNC_N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic ws,
    input  logic sd,
    output logic bclk_rise,
    output logic ws_s,
    output logic sd_s
);
    logic [SYNC_N-1:0] bclk_q, bclk_d;
    logic [SYNC_N-1:0] ws_q, ws_d;
    logic [SYNC_N-1:0] sd_q, sd_d;
    logic              bdly_q, bdly_d;

    always_comb begin
        bclk_d = {bclk_q[SYNC_N-2:0], bclk};
        ws_d   = {ws_q[SYNC_N-2:0], ws};
        sd_d   = {sd_q[SYNC_N-2:0], sd};
        bdly_d = bclk_q[SYNC_N-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_q <= '0;
            ws_q   <= '0;
            sd_q   <= '0;
            bdly_q <= 1'b0;
        end else begin
            bclk_q <= bclk_d;
            ws_q   <= ws_d;
            sd_q   <= sd_d;
            bdly_q <= bdly_d;
        end
    end

    // ws/sd share the bclk pipeline depth, so they line up with bclk_rise.
    assign bclk_rise = bclk_q[SYNC_N-1] & ~bdly_q;
    assign ws_s      = ws_q[SYNC_N-1];
    assign sd_s      = sd_q[SYNC_N-1];
endmodule

// File: rtl/i2s_rx.sv
// I2S receive deserializer: oversampled bclk/ws/sd -> stereo words + valid pulse.
// Ports: clki, rst_n (sync, active-low), init (enable), bus (i2s_rx_if.slave).
// Optional: define I2S_RX_ERR_EN for the sticky framing/oversample error flag.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SYNC_N = SYNC_N_DEF
) (
    input  logic     clki,
    input  logic     rst_n,
    input  logic     init,
    i2s_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    logic rise, ws_s, sd_s;

    i2s_sync #(.SYNC_N(SYNC_N)) u_sync (
        .clk       (clki),
        .rst_n     (rst_n),
        .bclk      (bus.bclk),
        .ws        (bus.ws),
        .sd        (bus.sd),
        .bclk_rise (rise),
        .ws_s      (ws_s),
        .sd_s      (sd_s)
    );

    i2s_rx_state_t     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ws_last_q, ws_last_d;
    logic              have_left_q, have_left_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] sh_n, word;
    logic [CNT_W-1:0]  cnt_n;
    logic              ws_chg, slot_end;

`ifdef I2S_RX_ERR_EN
    logic       err_q, err_d;
    logic [1:0] rhist_q, rhist_d;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ws_last_d   = ws_last_q;
        have_left_d = have_left_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        slot_end    = 1'b0;

        ws_chg = ws_s != ws_last_q;
        sh_n   = shift_q;
        cnt_n  = cnt_q;
        // Bits beyond DATA_W in a long slot are dropped.
        if (cnt_q < CNT_MAX) begin
            sh_n  = {shift_q[DATA_W-2:0], sd_s};
            cnt_n = cnt_q + 1'b1;
        end
        // MSB-justify; short slots are zero-padded at the bottom.
        word = sh_n << (CNT_MAX - cnt_n);

        if (!init) begin
            state_d     = IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            have_left_d = 1'b0;
            ws_last_d   = ws_s;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = SYNC;
                    ws_last_d = ws_s;
                end
                SYNC: begin
                    if (rise && ws_chg) begin
                        ws_last_d = ws_s;
                        shift_d   = '0;
                        cnt_d     = '0;
                        state_d   = (ws_s == WS_LEFT) ? LEFT : RIGHT;
                    end
                end
                LEFT, RIGHT: begin
                    if (rise && ws_chg) begin
                        slot_end  = 1'b1;
                        ws_last_d = ws_s;
                        shift_d   = '0;
                        cnt_d     = '0;
                        state_d   = (ws_s == WS_LEFT) ? LEFT : RIGHT;
                        if (state_q == LEFT) begin
                            left_hold_d = word;
                            have_left_d = 1'b1;
                        end else if (have_left_q) begin
                            // A right slot with no preceding left is discarded.
                            left_d      = left_hold_q;
                            right_d     = word;
                            valid_d     = 1'b1;
                            have_left_d = 1'b0;
                        end
                    end else if (rise) begin
                        shift_d = sh_n;
                        cnt_d   = cnt_n;
                    end
                end
            endcase
        end
    end

`ifdef I2S_RX_ERR_EN
    always_comb begin
        err_d   = err_q;
        rhist_d = {rhist_q[0], rise};
        if (!init) begin
            err_d = 1'b0;
        end else begin
            if (slot_end && cnt_n != CNT_MAX)
                err_d = 1'b1;
            // Rises closer than 3 clki cycles: bclk too fast to oversample.
            if (rise && (|rhist_q))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            rhist_q <= '0;
        end else begin
            err_q   <= err_d;
            rhist_q <= rhist_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ws_last_q   <= 1'b0;
            have_left_q <= 1'b0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ws_last_q   <= ws_last_d;
            have_left_q <= have_left_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.left_data   = left_q;
    assign bus.right_data  = right_q;
    assign bus.frame_valid = valid_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table vectors, corner sequences,
// and a random jittered stream against a queue-based frame model.
module tb_i2s_rx;
`ifdef I2S_RX_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] lw;
        logic [31:0] rw;
        int          n;
        int          half;
        logic [15:0] el;
        logic [15:0] er;
        logic        e;
    } vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } frm_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0;

    int total = 0;
    int bad = 0;
    int frm_cnt = 0;
    int base = 4;
    bit jit = 1'b0;
    logic prev_v = 1'b0;
    frm_t exp_q[$];
    vec_t tbl[6];

    i2s_rx_if #(.DATA_W(16)) bus ();

    i2s_rx #(.DATA_W(16), .SYNC_N(2)) dut (
        .clki  (clk),
        .rst_n (rst_n),
        .init  (init),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: keep the top 16 bits of an n-bit MSB-first word.
    function automatic logic [15:0] justify(input logic [31:0] w, input int n);
        logic [31:0] t;
        if (n >= 16) t = w >> (n - 16);
        else t = w << (16 - n);
        return t[15:0];
    endfunction

    function automatic int hp();
        if (jit) return base + int'($urandom_range(0, 4)) - 2;
        return base;
    endfunction

    always @(negedge clk) begin
        if (prev_v) begin
            total++;
            if (bus.frame_valid) begin
                bad++;
                $display("FAIL pulse_width: valid high 2 cycles");
            end
        end
        if (bus.frame_valid && !prev_v) begin
            frm_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: L=%h R=%h",
                         bus.left_data, bus.right_data);
            end else begin
                frm_t f;
                f = exp_q.pop_front();
                chk("frame_left", 32'(bus.left_data), 32'(f.l));
                chk("frame_right", 32'(bus.right_data), 32'(f.r));
            end
        end
        prev_v = bus.frame_valid;
    end

    task automatic send_bit(input logic w, input logic d, input int hl,
                            input int hh);
        bus.bclk = 1'b0;
        bus.ws   = w;
        bus.sd   = d;
        repeat (hl) @(negedge clk);
        bus.bclk = 1'b1;
        repeat (hh) @(negedge clk);
    endtask

    // I2S slot: the LSB goes out with ws already showing the next channel.
    task automatic send_slot(input logic c, input logic nc,
                             input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit((i == 0) ? nc : c, w[i], hp(), hp());
    endtask

    task automatic restart();
        init = 1'b0;
        bus.bclk = 1'b0;
        bus.ws = 1'b1;
        bus.sd = 1'b0;
        repeat (6) @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        frm_cnt = 0;
    endtask

    task automatic wait_frames(input string name, input int n);
        for (int k = 0; k < 400 && frm_cnt < n; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk(name, 32'(frm_cnt), 32'(n));
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        frm_t f;
        logic [31:0] lw, rw;
        int n;

        tbl[0] = '{32'hA5C3, 32'h0F0F, 16, 35, 16'hA5C3, 16'h0F0F, 1'b0};
        tbl[1] = '{32'h12345678, 32'hCAFEBABE, 32, 4, 16'h1234, 16'hCAFE, 1'b0};
        tbl[2] = '{32'hABC, 32'h123, 12, 4, 16'hABC0, 16'h1230, 1'b1};
        tbl[3] = '{32'hFFFF, 32'h0000, 16, 4, 16'hFFFF, 16'h0000, 1'b0};
        tbl[4] = '{32'h8000, 32'h0001, 16, 5, 16'h8000, 16'h0001, 1'b0};
        tbl[5] = '{32'hABCDEF, 32'h00F00F, 24, 4, 16'hABCD, 16'h00F0, 1'b0};

        bus.bclk = 1'b0;
        bus.ws = 1'b1;
        bus.sd = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_left", 32'(bus.left_data), 32'd0);
        chk("rst_right", 32'(bus.right_data), 32'd0);
        chk("rst_valid", 32'(bus.frame_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: lead-in right slot, then one full L/R pair.
        for (int v = 0; v < 6; v++) begin
            restart();
            base = tbl[v].half;
            jit = 1'b0;
            send_slot(1'b1, 1'b0, 32'h5555, 16);
            f.l = tbl[v].el;
            f.r = tbl[v].er;
            exp_q.push_back(f);
            send_slot(1'b0, 1'b1, tbl[v].lw, tbl[v].n);
            send_slot(1'b1, 1'b0, tbl[v].rw, tbl[v].n);
            wait_frames($sformatf("tbl%0d_count", v), 1);
            chk($sformatf("tbl%0d_err", v), 32'(bus.err),
                32'(tbl[v].e & ERR_EN));
        end

        // Start mid-right-slot: partial slot ignored.
        restart();
        base = 4;
        send_slot(1'b1, 1'b0, 32'h7F, 7);
        f.l = 16'h1357;
        f.r = 16'h2468;
        exp_q.push_back(f);
        send_slot(1'b0, 1'b1, 32'h1357, 16);
        send_slot(1'b1, 1'b0, 32'h2468, 16);
        wait_frames("midright_count", 1);

        // Short slot error is sticky across a later good pair.
        restart();
        send_slot(1'b1, 1'b0, 32'h0, 16);
        f.l = 16'hABC0;
        f.r = 16'hDEF0;
        exp_q.push_back(f);
        send_slot(1'b0, 1'b1, 32'hABC, 12);
        send_slot(1'b1, 1'b0, 32'hDEF, 12);
        f.l = 16'h1111;
        f.r = 16'h2222;
        exp_q.push_back(f);
        send_slot(1'b0, 1'b1, 32'h1111, 16);
        send_slot(1'b1, 1'b0, 32'h2222, 16);
        wait_frames("sticky_count", 2);
        chk("sticky_err", 32'(bus.err), 32'(ERR_EN));

        // init drop mid-left-slot: outputs held, partial work discarded.
        send_slot(1'b0, 1'b0, 32'hAA, 8);
        init = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_left", 32'(bus.left_data), 32'h1111);
        chk("hold_right", 32'(bus.right_data), 32'h2222);
        chk("init_clr_err", 32'(bus.err), 32'd0);
        init = 1'b1;
        repeat (2) @(negedge clk);
        frm_cnt = 0;
        send_slot(1'b0, 1'b1, 32'hAA, 8);
        send_slot(1'b1, 1'b0, 32'h9999, 16);
        f.l = 16'h3333;
        f.r = 16'h4444;
        exp_q.push_back(f);
        send_slot(1'b0, 1'b1, 32'h3333, 16);
        send_slot(1'b1, 1'b0, 32'h4444, 16);
        wait_frames("reinit_count", 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_left", 32'(bus.left_data), 32'd0);
        chk("rst2_right", 32'(bus.right_data), 32'd0);
        chk("rst2_err", 32'(bus.err), 32'd0);

        // bclk far too fast: rises 2 cycles apart.
        restart();
        send_slot(1'b1, 1'b0, 32'h0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1, 1);
        repeat (5) @(negedge clk);
        chk("overs_err", 32'(bus.err), 32'(ERR_EN));

        // 100 random frames, random slot widths, jittered bclk.
        restart();
        base = 4;
        jit = 1'b1;
        send_slot(1'b1, 1'b0, 32'h0, 16);
        for (int k = 0; k < 100; k++) begin
            lw = $urandom;
            rw = $urandom;
            case ($urandom_range(0, 2))
                0: n = 16;
                1: n = 20;
                default: n = 32;
            endcase
            f.l = justify(lw, n);
            f.r = justify(rw, n);
            exp_q.push_back(f);
            send_slot(1'b0, 1'b1, lw, n);
            send_slot(1'b1, 1'b0, rw, n);
        end
        wait_frames("rand_count", 100);
        chk("rand_err", 32'(bus.err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
